// File: rtl/nts_dispatcher_multibuf.sv
// Frame dispatcher: receives frames into a ring of packet buffers and presents them in commit order.
// Define NTS_DISPATCHER_MULTIBUF_STATS_EN to implement the saturating dropped-frame counter.
module nts_dispatcher_multibuf #(
  parameter int ADDR_WIDTH = 8,
  parameter int BUF_BITS   = 1
) (
  input  logic                  i_clk,
  input  logic                  i_areset,
  input  logic [7:0]            i_rx_data_valid,
  input  logic [63:0]           i_rx_data,
  input  logic                  i_rx_good_frame,
  input  logic                  i_rx_bad_frame,
  input  logic                  i_process_frame,
  output logic                  o_dispatch_packet_available,
  input  logic                  i_dispatch_packet_read_discard,
  output logic [ADDR_WIDTH-1:0] o_dispatch_counter,
  output logic [7:0]            o_dispatch_data_valid,
  output logic                  o_dispatch_fifo_empty,
  input  logic                  i_dispatch_fifo_rd_en,
  output logic [63:0]           o_dispatch_fifo_rd_data,
  output logic [BUF_BITS:0]     o_dispatch_buffers_free,
  output logic [31:0]           o_drop_counter
);

  localparam int NBUF      = 1 << BUF_BITS;
  localparam int MEM_WORDS = NBUF << ADDR_WIDTH;

  typedef enum logic [1:0] {IDLE, WRITE, WAIT_COMMIT, DROP} state_t;

  state_t                state, next_state;
  logic [63:0]           mem [MEM_WORDS];
  logic [NBUF-1:0]       full;
  logic [BUF_BITS-1:0]   wr_idx, rd_idx, tgt;
  logic [ADDR_WIDTH-1:0] addr, next_addr;
  logic [ADDR_WIDTH-1:0] last_addr [NBUF];
  logic [7:0]            last_valid [NBUF];
  logic [ADDR_WIDTH:0]   rd_ptr;
  logic [63:0]           rd_data;
  logic [BUF_BITS:0]     free_cnt;
  logic                  hold, available, empty, discard, rd_fire;
  logic                  we, latch, commit, drop, start;
  logic                  rx_valid, frame_end;

  assign rx_valid  = |i_rx_data_valid;
  assign frame_end = i_rx_good_frame | i_rx_bad_frame;

  always_ff @(posedge i_clk or posedge i_areset) begin
    if (i_areset) state <= IDLE;
    else          state <= next_state;
  end

  // addr holds the address of the last word written, so a word arriving at the top address overflows
  always_comb begin
    next_state = state;
    tgt        = wr_idx;
    next_addr  = addr;
    we         = 1'b0;
    latch      = 1'b0;
    commit     = 1'b0;
    drop       = 1'b0;
    start      = 1'b0;
    case (state)
      IDLE: start = rx_valid;
      WRITE: begin
        if (rx_valid) begin
          if (addr == '1) begin
            drop       = 1'b1;
            next_state = frame_end ? IDLE : DROP;
          end else begin
            we        = 1'b1;
            next_addr = addr + ADDR_WIDTH'(1);
            if (i_rx_good_frame) begin
              latch      = 1'b1;
              next_state = WAIT_COMMIT;
            end else if (i_rx_bad_frame) begin
              drop       = 1'b1;
              next_state = IDLE;
            end
          end
        end else if (i_rx_bad_frame) begin
          drop       = 1'b1;
          next_state = IDLE;
        end
      end
      WAIT_COMMIT: begin
        if (i_process_frame) begin
          commit     = 1'b1;
          next_state = IDLE;
          start      = rx_valid;
          tgt        = wr_idx + BUF_BITS'(1);
        end else if (rx_valid) begin
          drop  = 1'b1;
          start = 1'b1;
        end
      end
      DROP: if (frame_end) next_state = IDLE;
      default: next_state = IDLE;
    endcase
    // A new frame's first word, arriving from IDLE or pre-empting a pending commit
    if (start) begin
      if (!full[tgt]) begin
        we        = 1'b1;
        next_addr = '0;
        if (i_rx_good_frame) begin
          latch      = 1'b1;
          next_state = WAIT_COMMIT;
        end else if (i_rx_bad_frame) begin
          drop       = 1'b1;
          next_state = IDLE;
        end else begin
          next_state = WRITE;
        end
      end else begin
        drop       = 1'b1;
        next_state = frame_end ? IDLE : DROP;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_areset) begin
    if (i_areset) begin
      addr   <= '0;
      wr_idx <= '0;
      for (int i = 0; i < NBUF; i++) begin
        last_addr[i]  <= '0;
        last_valid[i] <= '0;
      end
    end else begin
      addr <= next_addr;
      if (commit) wr_idx <= wr_idx + BUF_BITS'(1);
      if (latch) begin
        last_addr[tgt]  <= next_addr;
        last_valid[tgt] <= i_rx_data_valid;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (we) mem[{tgt, next_addr}] <= i_rx_data;
  end

  // hold forces one idle cycle between releasing a buffer and presenting the next
  assign available = full[rd_idx] & ~hold;
  assign empty     = ~available | (rd_ptr > {1'b0, last_addr[rd_idx]});
  assign discard   = i_dispatch_packet_read_discard & available;
  assign rd_fire   = i_dispatch_fifo_rd_en & ~empty;

  always_ff @(posedge i_clk or posedge i_areset) begin
    if (i_areset) begin
      full    <= '0;
      rd_idx  <= '0;
      rd_ptr  <= '0;
      hold    <= 1'b0;
      rd_data <= '0;
    end else begin
      hold <= discard;
      if (discard) begin
        full[rd_idx] <= 1'b0;
        rd_idx       <= rd_idx + BUF_BITS'(1);
        rd_ptr       <= '0;
      end else if (rd_fire) begin
        rd_ptr <= rd_ptr + (ADDR_WIDTH+1)'(1);
      end
      if (commit) full[wr_idx] <= 1'b1;
      if (rd_fire) rd_data <= mem[{rd_idx, rd_ptr[ADDR_WIDTH-1:0]}];
    end
  end

  always_comb begin
    free_cnt = '0;
    for (int i = 0; i < NBUF; i++) free_cnt = free_cnt + (BUF_BITS+1)'(~full[i]);
  end

  assign o_dispatch_packet_available = available;
  assign o_dispatch_counter          = available ? last_addr[rd_idx] : '0;
  assign o_dispatch_data_valid       = available ? last_valid[rd_idx] : '0;
  assign o_dispatch_fifo_empty       = empty;
  assign o_dispatch_fifo_rd_data     = rd_data;
  assign o_dispatch_buffers_free     = free_cnt;

`ifdef NTS_DISPATCHER_MULTIBUF_STATS_EN
  logic [31:0] drop_count;

  always_ff @(posedge i_clk or posedge i_areset) begin
    if (i_areset)                       drop_count <= '0;
    else if (drop && drop_count != '1) drop_count <= drop_count + 32'd1;
  end

  assign o_drop_counter = drop_count;
`else
  // Drop events are discarded when statistics are compiled out
  assign o_drop_counter = {31'd0, drop & 1'b0};
`endif

endmodule

// File: tb/tb_nts_dispatcher_multibuf.sv
// Directed self-checking bench for nts_dispatcher_multibuf (ADDR_WIDTH=3, BUF_BITS=1).
// Expected drop counts follow NTS_DISPATCHER_MULTIBUF_STATS_EN.
module tb_nts_dispatcher_multibuf;

  localparam int AW = 3;
  localparam int BB = 1;
`ifdef NTS_DISPATCHER_MULTIBUF_STATS_EN
  localparam int STATS = 1;
`else
  localparam int STATS = 0;
`endif

  logic          clk = 1'b0;
  logic          areset;
  logic [7:0]    rx_data_valid;
  logic [63:0]   rx_data;
  logic          rx_good_frame, rx_bad_frame, process_frame;
  logic          packet_available, read_discard;
  logic [AW-1:0] dispatch_counter;
  logic [7:0]    dispatch_data_valid;
  logic          fifo_empty, fifo_rd_en;
  logic [63:0]   fifo_rd_data;
  logic [BB:0]   buffers_free;
  logic [31:0]   drop_counter;

  int checks    = 0;
  int errors    = 0;
  int exp_drops = 0;

  localparam logic [63:0] W0 = 64'h01020304_05060708;
  localparam logic [63:0] W1 = 64'h00000002_20202020;
  localparam logic [63:0] W2 = 64'h00000003_30303030;

  always #5 clk = ~clk;

  nts_dispatcher_multibuf #(.ADDR_WIDTH(AW), .BUF_BITS(BB)) dut (
    .i_clk                          (clk),
    .i_areset                       (areset),
    .i_rx_data_valid                (rx_data_valid),
    .i_rx_data                      (rx_data),
    .i_rx_good_frame                (rx_good_frame),
    .i_rx_bad_frame                 (rx_bad_frame),
    .i_process_frame                (process_frame),
    .o_dispatch_packet_available    (packet_available),
    .i_dispatch_packet_read_discard (read_discard),
    .o_dispatch_counter             (dispatch_counter),
    .o_dispatch_data_valid          (dispatch_data_valid),
    .o_dispatch_fifo_empty          (fifo_empty),
    .i_dispatch_fifo_rd_en          (fifo_rd_en),
    .o_dispatch_fifo_rd_data        (fifo_rd_data),
    .o_dispatch_buffers_free        (buffers_free),
    .o_drop_counter                 (drop_counter)
  );

  task automatic check_output(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_stimulus(input logic [7:0] dv, input logic [63:0] data, input logic good,
                                input logic bad, input logic process, input logic disc, input logic rd);
    rx_data_valid = dv;
    rx_data       = data;
    rx_good_frame = good;
    rx_bad_frame  = bad;
    process_frame = process;
    read_discard  = disc;
    fifo_rd_en    = rd;
    tick();
    rx_data_valid = '0;
    rx_data       = '0;
    rx_good_frame = 1'b0;
    rx_bad_frame  = 1'b0;
    process_frame = 1'b0;
    read_discard  = 1'b0;
    fifo_rd_en    = 1'b0;
  endtask

  task automatic send_word(input logic [7:0] dv, input logic [63:0] data, input logic good, input logic bad);
    apply_stimulus(dv, data, good, bad, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic check_reset_state(input string tag);
    check_output({tag, " available"}, packet_available, 1'b0);
    check_output({tag, " counter"}, dispatch_counter, '0);
    check_output({tag, " data_valid"}, dispatch_data_valid, 8'h00);
    check_output({tag, " empty"}, fifo_empty, 1'b1);
    check_output({tag, " rd_data"}, fifo_rd_data, 64'h0);
    check_output({tag, " buffers_free"}, buffers_free, 2);
    check_output({tag, " drop_counter"}, drop_counter, 32'd0);
  endtask

  initial begin
    areset        = 1'b1;
    rx_data_valid = '0;
    rx_data       = '0;
    rx_good_frame = 1'b0;
    rx_bad_frame  = 1'b0;
    process_frame = 1'b0;
    read_discard  = 1'b0;
    fifo_rd_en    = 1'b0;
    tick();
    tick();
    check_reset_state("reset");
    areset = 1'b0;
    tick();

    $display("[TB] basic three-word frame");
    send_word(8'hff, W0, 1'b0, 1'b0);
    send_word(8'hff, W1, 1'b0, 1'b0);
    send_word(8'hff, W2, 1'b1, 1'b0);
    check_output("not available before commit", packet_available, 1'b0);
    apply_stimulus('0, '0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    check_output("basic available", packet_available, 1'b1);
    check_output("basic counter", dispatch_counter, 2);
    check_output("basic data_valid", dispatch_data_valid, 8'hff);
    check_output("basic empty before read", fifo_empty, 1'b0);
    check_output("basic buffers_free", buffers_free, 1);
    apply_stimulus('0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check_output("basic read 0", fifo_rd_data, W0);
    apply_stimulus('0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check_output("basic read 1", fifo_rd_data, W1);
    check_output("basic empty after 2 reads", fifo_empty, 1'b0);
    apply_stimulus('0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check_output("basic read 2", fifo_rd_data, W2);
    check_output("basic empty after 3 reads", fifo_empty, 1'b1);
    apply_stimulus('0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check_output("read when empty holds", fifo_rd_data, W2);
    apply_stimulus('0, '0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    check_output("basic discard available", packet_available, 1'b0);
    check_output("basic discard counter", dispatch_counter, 0);
    check_output("basic discard buffers_free", buffers_free, 2);
    apply_stimulus('0, '0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    check_output("discard while idle ignored", buffers_free, 2);

    $display("[TB] bad frame");
    send_word(8'hff, 64'hbad0, 1'b0, 1'b0);
    send_word(8'hff, 64'hbad1, 1'b0, 1'b1);
    exp_drops += STATS;
    apply_stimulus('0, '0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    check_output("bad available", packet_available, 1'b0);
    check_output("bad buffers_free", buffers_free, 2);
    check_output("bad drop_counter", drop_counter, exp_drops);

    $display("[TB] both buffers full, third frame dropped");
    send_word(8'hff, 64'haa00, 1'b0, 1'b0);
    send_word(8'h01, 64'haa01, 1'b1, 1'b0);
    apply_stimulus('0, '0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    send_word(8'hff, 64'hbb00, 1'b0, 1'b0);
    send_word(8'hff, 64'hbb01, 1'b0, 1'b0);
    send_word(8'h3f, 64'hbb02, 1'b1, 1'b0);
    apply_stimulus('0, '0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    check_output("full buffers_free", buffers_free, 0);
    check_output("full counter first", dispatch_counter, 1);
    check_output("full data_valid first", dispatch_data_valid, 8'h01);
    send_word(8'hff, 64'hcc00, 1'b0, 1'b0);
    send_word(8'hff, 64'hcc01, 1'b1, 1'b0);
    exp_drops += STATS;
    check_output("full drop_counter", drop_counter, exp_drops);
    check_output("full buffers_free after drop", buffers_free, 0);
    apply_stimulus('0, '0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    check_output("gap after discard", packet_available, 1'b0);
    tick();
    check_output("second packet available", packet_available, 1'b1);
    check_output("second packet counter", dispatch_counter, 2);
    check_output("second packet data_valid", dispatch_data_valid, 8'h3f);
    apply_stimulus('0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check_output("second packet read 0", fifo_rd_data, 64'hbb00);
    apply_stimulus('0, '0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    check_output("second discard buffers_free", buffers_free, 2);

    $display("[TB] overflow and depth boundary");
    for (int i = 0; i < 9; i++) send_word(8'hff, 64'h900 + 64'(i), i == 8, 1'b0);
    exp_drops += STATS;
    apply_stimulus('0, '0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    check_output("overflow available", packet_available, 1'b0);
    check_output("overflow buffers_free", buffers_free, 2);
    check_output("overflow drop_counter", drop_counter, exp_drops);
    send_word(8'hff, 64'hd0, 1'b0, 1'b0);
    send_word(8'h03, 64'hd1, 1'b1, 1'b0);
    apply_stimulus('0, '0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    check_output("post-overflow counter", dispatch_counter, 1);
    check_output("post-overflow data_valid", dispatch_data_valid, 8'h03);
    apply_stimulus('0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check_output("post-overflow read 0", fifo_rd_data, 64'hd0);
    apply_stimulus('0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check_output("post-overflow read 1", fifo_rd_data, 64'hd1);
    check_output("post-overflow empty", fifo_empty, 1'b1);
    apply_stimulus('0, '0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 8; i++) send_word(8'hff, 64'he00 + 64'(i), i == 7, 1'b0);
    apply_stimulus('0, '0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    check_output("full-depth counter", dispatch_counter, 7);
    for (int i = 0; i < 8; i++) begin
      apply_stimulus('0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      check_output("full-depth read", fifo_rd_data, 64'he00 + 64'(i));
    end
    check_output("full-depth empty", fifo_empty, 1'b1);
    check_output("full-depth drop_counter", drop_counter, exp_drops);
    apply_stimulus('0, '0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

    $display("[TB] commit and discard on one edge");
    send_word(8'hff, 64'hf0, 1'b0, 1'b0);
    send_word(8'hff, 64'hf1, 1'b1, 1'b0);
    apply_stimulus('0, '0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    send_word(8'hff, 64'h70, 1'b0, 1'b0);
    send_word(8'hff, 64'h71, 1'b0, 1'b0);
    send_word(8'h7f, 64'h72, 1'b1, 1'b0);
    check_output("pre-collision buffers_free", buffers_free, 1);
    check_output("pre-collision counter", dispatch_counter, 1);
    apply_stimulus('0, '0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    check_output("collision buffers_free", buffers_free, 1);
    check_output("collision gap", packet_available, 1'b0);
    tick();
    check_output("collision new available", packet_available, 1'b1);
    check_output("collision new counter", dispatch_counter, 2);
    check_output("collision new data_valid", dispatch_data_valid, 8'h7f);
    apply_stimulus('0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check_output("collision read 0", fifo_rd_data, 64'h70);
    apply_stimulus('0, '0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

    $display("[TB] reset mid-write and mid-read");
    send_word(8'hff, 64'h1111, 1'b0, 1'b0);
    send_word(8'hff, 64'h2222, 1'b0, 1'b0);
    areset = 1'b1;
    #2;
    check_reset_state("reset mid-write");
    tick();
    areset = 1'b0;
    exp_drops = 0;
    tick();
    send_word(8'hff, 64'h3333, 1'b0, 1'b0);
    send_word(8'h0f, 64'h4444, 1'b1, 1'b0);
    apply_stimulus('0, '0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    check_output("after reset counter", dispatch_counter, 1);
    check_output("after reset data_valid", dispatch_data_valid, 8'h0f);
    apply_stimulus('0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check_output("after reset read 0", fifo_rd_data, 64'h3333);
    areset = 1'b1;
    #2;
    check_reset_state("reset mid-read");
    tick();
    areset = 1'b0;
    tick();
    send_word(8'h1f, 64'h5555, 1'b1, 1'b0);
    apply_stimulus('0, '0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    check_output("single-word available", packet_available, 1'b1);
    check_output("single-word counter", dispatch_counter, 0);
    check_output("single-word data_valid", dispatch_data_valid, 8'h1f);
    apply_stimulus('0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check_output("single-word read", fifo_rd_data, 64'h5555);
    check_output("single-word empty", fifo_empty, 1'b1);
    check_output("final drop_counter", drop_counter, exp_drops);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
